// File: rtl/axis_burst_master_gen.sv
// AXI4-Stream burst traffic generator: after a start delay, emits BURST_LEN-beat
// bursts of an incrementing data pattern with TLAST on the final beat.
// Optional feature macro: AXIS_BURST_GEN_TUSER_EN (adds M_AXIS_TUSER, high on beat 1).
module axis_burst_master_gen #(
  parameter int unsigned C_M_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M_START_COUNT      = 32,
  parameter int unsigned BURST_LEN            = 8,
  parameter int unsigned NUM_BURSTS           = 0,
  parameter logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_INIT = C_M_AXIS_TDATA_WIDTH'(1)
) (
  input  logic                                M_AXIS_ACLK,
  input  logic                                M_AXIS_ARESETN,
  input  logic                                enable,
  output logic                                M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [(C_M_AXIS_TDATA_WIDTH/8)-1:0] M_AXIS_TSTRB,
  output logic                                M_AXIS_TLAST,
`ifdef AXIS_BURST_GEN_TUSER_EN
  output logic                                M_AXIS_TUSER,
`endif
  input  logic                                M_AXIS_TREADY,
  output logic                                busy,
  output logic [15:0]                         bursts_sent,
  output logic                                done
);

  localparam int unsigned DW     = C_M_AXIS_TDATA_WIDTH;
  localparam int unsigned DLY_W  = (C_M_START_COUNT > 1) ? $clog2(C_M_START_COUNT) : 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_START = 2'd1,
    S_SEND       = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  state_t              r_state, w_state;
  logic [DLY_W-1:0]    r_dly, w_dly;
  logic [BEAT_W-1:0]   r_beat, w_beat;
  logic [DW-1:0]       r_data, w_data;
  logic                r_tvalid, w_tvalid;
  logic                r_tlast, w_tlast;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic [15:0]         r_bursts, w_bursts;
  logic                w_accept;
  logic                w_last_burst;
`ifdef AXIS_BURST_GEN_TUSER_EN
  logic                r_tuser, w_tuser;
`endif

  assign w_accept     = r_tvalid & M_AXIS_TREADY;
  // Session ends when the burst just completed is the NUM_BURSTS-th one
  assign w_last_burst = (NUM_BURSTS != 0) && ((32'(r_bursts) + 32'd1) == NUM_BURSTS);

  // State and registered-output update
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state  <= S_IDLE;
      r_dly    <= '0;
      r_beat   <= '0;
      r_data   <= DATA_INIT;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_bursts <= 16'd0;
`ifdef AXIS_BURST_GEN_TUSER_EN
      r_tuser  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state;
      r_dly    <= w_dly;
      r_beat   <= w_beat;
      r_data   <= w_data;
      r_tvalid <= w_tvalid;
      r_tlast  <= w_tlast;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_bursts <= w_bursts;
`ifdef AXIS_BURST_GEN_TUSER_EN
      r_tuser  <= w_tuser;
`endif
    end
  end

  // Next-state and next-output logic; outputs only change on acceptance while valid
  always_comb begin
    w_state  = r_state;
    w_dly    = r_dly;
    w_beat   = r_beat;
    w_data   = r_data;
    w_tvalid = r_tvalid;
    w_tlast  = r_tlast;
    w_bursts = r_bursts;
`ifdef AXIS_BURST_GEN_TUSER_EN
    w_tuser  = r_tuser;
`endif
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_state  = S_WAIT_START;
          w_dly    = '0;
          w_bursts = 16'd0;
        end
      end
      S_WAIT_START: begin
        if (r_dly == DLY_W'(C_M_START_COUNT - 1)) begin
          w_state  = S_SEND;
          w_beat   = '0;
          w_tvalid = 1'b1;
          w_tlast  = (BURST_LEN == 1);
`ifdef AXIS_BURST_GEN_TUSER_EN
          w_tuser  = 1'b1;
`endif
        end else begin
          w_dly = r_dly + DLY_W'(1);
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_data = r_data + DW'(1);
`ifdef AXIS_BURST_GEN_TUSER_EN
          w_tuser = 1'b0;
`endif
          if (r_tlast) begin
            w_tvalid = 1'b0;
            w_tlast  = 1'b0;
            w_bursts = (r_bursts == 16'hFFFF) ? r_bursts : r_bursts + 16'd1;
            if (w_last_burst) begin
              w_state = S_DONE;
            end else if (!enable) begin
              w_state = S_IDLE;
            end else begin
              w_state = S_WAIT_START;
              w_dly   = '0;
            end
          end else begin
            w_beat  = r_beat + BEAT_W'(1);
            w_tlast = (BURST_LEN == 1) || (r_beat == BEAT_W'(BURST_LEN - 2));
          end
        end
      end
      S_DONE: begin
        w_tvalid = 1'b0;
        w_tlast  = 1'b0;
        if (!enable) begin
          w_state = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    w_busy = (w_state == S_WAIT_START) || (w_state == S_SEND);
    w_done = (w_state == S_DONE);
  end

  assign M_AXIS_TVALID = r_tvalid;
  assign M_AXIS_TDATA  = r_data;
  assign M_AXIS_TSTRB  = '1;
  assign M_AXIS_TLAST  = r_tlast;
  assign busy          = r_busy;
  assign done          = r_done;
  assign bursts_sent   = r_bursts;
`ifdef AXIS_BURST_GEN_TUSER_EN
  assign M_AXIS_TUSER  = r_tuser;
`endif

endmodule

// File: tb/tb_axis_burst_master_gen.sv
// Directed bench for axis_burst_master_gen: three instances (defaults, finite
// burst count, 8-bit wrap) share clock, reset, enable and TREADY.
module tb_axis_burst_master_gen;

  logic clk, rst_n, enable, tready;
  logic [1:0] sel;

  logic        d_tvalid, d_tlast, d_busy, d_done;
  logic [31:0] d_tdata;
  logic [3:0]  d_tstrb;
  logic [15:0] d_bursts;

  logic        n_tvalid, n_tlast, n_busy, n_done;
  logic [31:0] n_tdata;
  logic [3:0]  n_tstrb;
  logic [15:0] n_bursts;

  logic        e_tvalid, e_tlast, e_busy, e_done;
  logic [7:0]  e_tdata;
  logic [0:0]  e_tstrb;
  logic [15:0] e_bursts;

`ifdef AXIS_BURST_GEN_TUSER_EN
  logic d_tuser, n_tuser, e_tuser;
`endif

  logic        m_tvalid, m_tlast;
  logic [31:0] m_tdata;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] q_d[$];
  bit          q_l[$];
  int          q_c[$];
`ifdef AXIS_BURST_GEN_TUSER_EN
  bit          q_u[$];
`endif

  axis_burst_master_gen u_def (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable),
    .M_AXIS_TVALID(d_tvalid), .M_AXIS_TDATA(d_tdata), .M_AXIS_TSTRB(d_tstrb),
    .M_AXIS_TLAST(d_tlast),
`ifdef AXIS_BURST_GEN_TUSER_EN
    .M_AXIS_TUSER(d_tuser),
`endif
    .M_AXIS_TREADY(tready), .busy(d_busy), .bursts_sent(d_bursts), .done(d_done)
  );

  axis_burst_master_gen #(.C_M_START_COUNT(4), .NUM_BURSTS(3)) u_nb (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable),
    .M_AXIS_TVALID(n_tvalid), .M_AXIS_TDATA(n_tdata), .M_AXIS_TSTRB(n_tstrb),
    .M_AXIS_TLAST(n_tlast),
`ifdef AXIS_BURST_GEN_TUSER_EN
    .M_AXIS_TUSER(n_tuser),
`endif
    .M_AXIS_TREADY(tready), .busy(n_busy), .bursts_sent(n_bursts), .done(n_done)
  );

  axis_burst_master_gen #(.C_M_AXIS_TDATA_WIDTH(8), .C_M_START_COUNT(2), .BURST_LEN(3),
                          .DATA_INIT(8'hFE)) u_w8 (
    .M_AXIS_ACLK(clk), .M_AXIS_ARESETN(rst_n), .enable(enable),
    .M_AXIS_TVALID(e_tvalid), .M_AXIS_TDATA(e_tdata), .M_AXIS_TSTRB(e_tstrb),
    .M_AXIS_TLAST(e_tlast),
`ifdef AXIS_BURST_GEN_TUSER_EN
    .M_AXIS_TUSER(e_tuser),
`endif
    .M_AXIS_TREADY(tready), .busy(e_busy), .bursts_sent(e_bursts), .done(e_done)
  );

  // Stream under observation
  assign m_tvalid = (sel == 2'd0) ? d_tvalid : (sel == 2'd1) ? n_tvalid : e_tvalid;
  assign m_tlast  = (sel == 2'd0) ? d_tlast  : (sel == 2'd1) ? n_tlast  : e_tlast;
  assign m_tdata  = (sel == 2'd0) ? d_tdata  : (sel == 2'd1) ? n_tdata  : 32'(e_tdata);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enable = 1'b0;
    tready = 1'b1;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Edges from the enable-sampling edge until TVALID is seen high
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_tvalid && n < 200);
  endtask

  // Gather accepted beats; bp selects TREADY pattern 1,0,0 repeating
  task automatic collect(input int nbeats, input int maxcyc, input bit bp);
    int cyc = 0;
    int ph = 0;
    logic [31:0] pd = '0;
    logic pl = 1'b0;
    bit stalled = 1'b0;
    q_d.delete(); q_l.delete(); q_c.delete();
`ifdef AXIS_BURST_GEN_TUSER_EN
    q_u.delete();
`endif
    while (q_d.size() < nbeats && cyc < maxcyc) begin
      tready = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      if (stalled) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", m_tdata, pd);
        chk("hold_last", 32'(m_tlast), 32'(pl));
      end
      if (m_tvalid && tready) begin
        q_d.push_back(m_tdata);
        q_l.push_back(m_tlast);
        q_c.push_back(cyc);
`ifdef AXIS_BURST_GEN_TUSER_EN
        q_u.push_back(d_tuser);
`endif
      end
      stalled = m_tvalid && !tready;
      pd = m_tdata;
      pl = m_tlast;
      tick();
      cyc++;
    end
    tready = 1'b1;
    if (q_d.size() < nbeats) chk("collect_timeout", 32'(q_d.size()), 32'(nbeats));
  endtask

  initial begin
    int n;
    int cnt;
    sel    = 2'd0;
    enable = 1'b0;
    tready = 1'b1;
    rst_n  = 1'b1;
    #2;

    // 1: default timing and data
    do_reset();
    chk("rst_tvalid", 32'(d_tvalid), 32'd0);
    chk("rst_tdata", d_tdata, 32'd1);
    chk("rst_tlast", 32'(d_tlast), 32'd0);
    chk("rst_busy", 32'(d_busy), 32'd0);
    chk("rst_done", 32'(d_done), 32'd0);
    chk("rst_bursts", 32'(d_bursts), 32'd0);
    chk("rst_tstrb", 32'(d_tstrb), 32'hF);
    enable = 1'b1;
    wait_valid(n);
    chk("t1_latency", 32'(n), 32'd33);
    collect(16, 300, 1'b0);
    for (int i = 0; i < q_d.size(); i++) begin
      chk($sformatf("t1_data%0d", i), q_d[i], 32'(i + 1));
      chk($sformatf("t1_last%0d", i), 32'(q_l[i]), 32'((i % 8) == 7));
`ifdef AXIS_BURST_GEN_TUSER_EN
      chk($sformatf("t1_user%0d", i), 32'(q_u[i]), 32'((i % 8) == 0));
`endif
    end
    if (q_c.size() == 16) begin
      chk("t1_b2b", 32'(q_c[7] - q_c[0]), 32'd7);
      chk("t1_gap", 32'(q_c[8] - q_c[7]), 32'd33);
    end

    // 2: backpressure 1,0,0 pattern
    do_reset();
    enable = 1'b1;
    wait_valid(n);
    collect(8, 100, 1'b1);
    for (int i = 0; i < q_d.size(); i++) begin
      chk($sformatf("t2_data%0d", i), q_d[i], 32'(i + 1));
      chk($sformatf("t2_last%0d", i), 32'(q_l[i]), 32'(i == 7));
    end

    // 3: finite burst count session
    sel = 2'd1;
    do_reset();
    enable = 1'b1;
    collect(24, 400, 1'b0);
    for (int i = 0; i < q_d.size(); i++)
      chk($sformatf("t3_data%0d", i), q_d[i], 32'(i + 1));
    chk("t3_done", 32'(n_done), 32'd1);
    chk("t3_bursts", 32'(n_bursts), 32'd3);
    chk("t3_busy_done", 32'(n_busy), 32'd0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (n_tvalid) cnt++;
      tick();
    end
    chk("t3_no_extra", 32'(cnt), 32'd0);
    chk("t3_done_held", 32'(n_done), 32'd1);
    enable = 1'b0;
    tick();
    chk("t3_idle_done", 32'(n_done), 32'd0);
    chk("t3_idle_busy", 32'(n_busy), 32'd0);
    chk("t3_idle_bursts", 32'(n_bursts), 32'd3);
    enable = 1'b1;
    tick();
    chk("t3_clr_bursts", 32'(n_bursts), 32'd0);
    chk("t3_rebusy", 32'(n_busy), 32'd1);
    collect(1, 50, 1'b0);
    if (q_d.size() == 1) chk("t3_resume_data", q_d[0], 32'd25);

    // 4: enable dropped after beat 3
    sel = 2'd0;
    do_reset();
    enable = 1'b1;
    collect(3, 100, 1'b0);
    enable = 1'b0;
    collect(5, 50, 1'b0);
    for (int i = 0; i < q_d.size(); i++) begin
      chk($sformatf("t4_data%0d", i), q_d[i], 32'(i + 4));
      chk($sformatf("t4_last%0d", i), 32'(q_l[i]), 32'(i == 4));
    end
    chk("t4_busy", 32'(d_busy), 32'd0);
    chk("t4_tvalid", 32'(d_tvalid), 32'd0);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (d_tvalid) cnt++;
      tick();
    end
    chk("t4_no_valid", 32'(cnt), 32'd0);

    // 5: 8-bit wrap-around
    sel = 2'd2;
    do_reset();
    chk("t5_rst_data", 32'(e_tdata), 32'hFE);
    chk("t5_tstrb", 32'(e_tstrb), 32'd1);
    enable = 1'b1;
    collect(6, 100, 1'b0);
    begin
      logic [7:0] exp_d;
      exp_d = 8'hFE;
      for (int i = 0; i < q_d.size(); i++) begin
        chk($sformatf("t5_data%0d", i), q_d[i], 32'(exp_d));
        chk($sformatf("t5_last%0d", i), 32'(q_l[i]), 32'((i % 3) == 2));
        exp_d = exp_d + 8'd1;
      end
    end

    // 6: async reset mid-burst while stalled
    sel = 2'd0;
    do_reset();
    enable = 1'b1;
    collect(3, 100, 1'b0);
    tready = 1'b0;
    tick();
    tick();
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(d_tvalid), 32'd0);
    chk("t6_rst_tdata", d_tdata, 32'd1);
    chk("t6_rst_tlast", 32'(d_tlast), 32'd0);
    chk("t6_rst_busy", 32'(d_busy), 32'd0);
    tick();
    rst_n  = 1'b1;
    tready = 1'b1;
    tick();
    enable = 1'b1;
    wait_valid(n);
    chk("t6_latency", 32'(n), 32'd33);
    collect(8, 50, 1'b0);
    for (int i = 0; i < q_d.size(); i++) begin
      chk($sformatf("t6_data%0d", i), q_d[i], 32'(i + 1));
      chk($sformatf("t6_last%0d", i), 32'(q_l[i]), 32'(i == 7));
`ifdef AXIS_BURST_GEN_TUSER_EN
      chk($sformatf("t6_user%0d", i), 32'(q_u[i]), 32'(i == 0));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
